// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: queues valid/ready ALU commands in a small FIFO and drives
// the operand and select registers of the external 4-bit ALU. After a
// programmable settle time it captures the ALU result and returns it on a
// valid/ready response stream.
// Optional macro ALU_CHECK_EN: builds an internal reference ALU and raises a
// sticky mismatch flag when the captured alu_y disagrees with it.
module alu_cmd_issuer #(
  parameter int DEPTH         = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [1:0] alu_sel,
  input  logic [3:0] alu_y,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_y,
  output logic [1:0] rsp_op,
  output logic [7:0] op_count,
  output logic       busy,
  output logic       mismatch
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [AW-1:0] PTR_ONE     = AW'(1);
  localparam logic [AW:0]   COUNT_ONE   = (AW + 1)'(1);
  localparam logic [AW:0]   FULL_COUNT  = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  localparam logic [CW-1:0] SETTLE_INIT = CW'(SETTLE_CYCLES);

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("alu_cmd_issuer: SETTLE_CYCLES must be at least 1");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("alu_cmd_issuer: DEPTH must be a power of two and at least 2");
  end

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state;
  state_t        next_state;
  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [CW-1:0] settle_cnt;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic          capture;
  logic          done;
  logic [9:0]    head;

  assign empty     = (count == '0);
  assign full      = (count == FULL_COUNT);
  assign cmd_ready = !full;
  assign push      = cmd_valid && cmd_ready;
  assign head      = mem[rd_ptr];
  assign busy      = (state != IDLE) || !empty;

  // Command storage; entries need no reset because occupancy guards reads.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_op, cmd_a, cmd_b};
  end

  // FIFO pointers and occupancy; a full FIFO never pushes, an empty one never pops.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + COUNT_ONE;
        2'b01:   count <= count - COUNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Sequencer transitions; a retired response chains straight into the next command.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!empty) next_state = WAIT;
      WAIT:    if (settle_cnt == CNT_ONE) next_state = RESP;
      RESP:    if (rsp_ready) next_state = empty ? IDLE : WAIT;
      default: next_state = IDLE;
    endcase
  end

  // Sequencer strobes: when to pop/load, capture the ALU, and retire a response.
  always_comb begin
    pop     = 1'b0;
    capture = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: pop = !empty;
      WAIT: capture = (settle_cnt == CNT_ONE);
      RESP: begin
        done = rsp_ready;
        pop  = rsp_ready && !empty;
      end
      default: ;
    endcase
  end

  // ALU drive registers change only when a command is loaded, so they stay put while settling.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_sel <= '0;
    end else if (pop) begin
      alu_sel <= head[9:8];
      alu_a   <= head[7:4];
      alu_b   <= head[3:0];
    end
  end

  // Settle counter: loaded with the settle time on a load, counts down while waiting.
  always_ff @(posedge clk) begin
    if (rst)                  settle_cnt <= '0;
    else if (pop)             settle_cnt <= SETTLE_INIT;
    else if (state == WAIT)   settle_cnt <= settle_cnt - CNT_ONE;
  end

  // Response holding register and completion counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_y     <= '0;
      rsp_op    <= '0;
      op_count  <= '0;
    end else begin
      if (capture) begin
        rsp_valid <= 1'b1;
        rsp_y     <= alu_y;
        rsp_op    <= alu_sel;
      end
      if (done) begin
        rsp_valid <= 1'b0;
        op_count  <= op_count + 8'd1;
      end
    end
  end

`ifdef ALU_CHECK_EN
  logic [3:0] model_y;

  // Reference ALU evaluated on the registered drive lines.
  always_comb begin
    model_y = '0;
    case (alu_sel)
      2'b00:   model_y = alu_a + alu_b;
      2'b01:   model_y = alu_a - alu_b;
      2'b10:   model_y = alu_a & alu_b;
      default: model_y = alu_a | alu_b;
    endcase
  end

  // Sticky flag set when the external ALU disagrees at the capture edge.
  always_ff @(posedge clk) begin
    if (rst)                               mismatch <= 1'b0;
    else if (capture && (alu_y != model_y)) mismatch <= 1'b1;
  end
`else
  assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb_alu_cmd_issuer: drives alu_cmd_issuer with directed and random commands,
// emulates the external ALU, and compares every response against a queue of
// results computed directly from the accepted commands.
module tb_alu_cmd_issuer;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [1:0] alu_sel;
  logic [3:0] alu_y;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_y;
  logic [1:0] rsp_op;
  logic [7:0] op_count;
  logic       busy;
  logic       mismatch;

  typedef struct {
    logic [1:0] op;
    logic [3:0] y;
  } exp_t;

  exp_t exp_q[$];
  int   exp_count;
  int   check_count;
  int   pass_count;
  bit   rand_ready;
  bit   zero_alu;

  alu_cmd_issuer #(.DEPTH(4), .SETTLE_CYCLES(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_y     (alu_y),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_y     (rsp_y),
    .rsp_op    (rsp_op),
    .op_count  (op_count),
    .busy      (busy),
    .mismatch  (mismatch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Arithmetic meaning of each opcode, results taken modulo 16.
  function automatic logic [3:0] alu_ref(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    int r;
    case (op)
      2'd0:    r = (int'(a) + int'(b)) % 16;
      2'd1:    r = (int'(a) - int'(b) + 16) % 16;
      2'd2:    r = int'(a & b);
      default: r = int'(a | b);
    endcase
    return 4'(r);
  endfunction

  // External combinational ALU, optionally forced to zero.
  always_comb alu_y = zero_alu ? 4'd0 : alu_ref(alu_sel, alu_a, alu_b);

  task automatic checkOutput(input string tag, input int actual, input int expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
  endtask

  // Reference model: records accepted commands, retires them on response handshakes.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      exp_count = 0;
    end else begin
      checkOutput("op_count", int'(op_count), exp_count);
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("rsp_spurious", 1, 0);
        end else begin
          checkOutput("rsp_y", int'(rsp_y), int'(exp_q[0].y));
          checkOutput("rsp_op", int'(rsp_op), int'(exp_q[0].op));
          if (rsp_ready) begin
            void'(exp_q.pop_front());
            exp_count = (exp_count + 1) % 256;
          end
        end
      end
      if (cmd_valid && cmd_ready) begin
        exp_t e;
        e.op = cmd_op;
        e.y  = zero_alu ? 4'd0 : alu_ref(cmd_op, cmd_a, cmd_b);
        exp_q.push_back(e);
      end
    end
  end

  task automatic stepCycle();
    @(posedge clk);
    #1;
    if (rand_ready) rsp_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    bit accepted = 0;
    int waited = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    while (!accepted) begin
      @(negedge clk);
      accepted = cmd_ready;
      stepCycle();
      if (!accepted) begin
        waited++;
        if (waited > 300) begin
          checkOutput("cmd_accept_timeout", 0, 1);
          accepted = 1;
        end
      end
    end
    cmd_valid = 1'b0;
  endtask

  task automatic waitIdle();
    bit idle = 0;
    int waited = 0;
    rand_ready = 0;
    rsp_ready  = 1'b1;
    while (!idle) begin
      @(negedge clk);
      idle = !busy && !rsp_valid;
      @(posedge clk);
      #1;
      waited++;
      if (!idle && waited > 300) begin
        checkOutput("drain_timeout", 0, 1);
        idle = 1;
      end
    end
  endtask

  task automatic doReset();
    cmd_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int remaining;
    rst         = 1'b1;
    cmd_valid   = 1'b0;
    cmd_op      = '0;
    cmd_a       = '0;
    cmd_b       = '0;
    rsp_ready   = 1'b1;
    rand_ready  = 0;
    zero_alu    = 0;
    check_count = 0;
    pass_count  = 0;
    exp_count   = 0;

    // Reset state
    doReset();
    checkOutput("rst_cmd_ready", int'(cmd_ready), 1);
    checkOutput("rst_rsp_valid", int'(rsp_valid), 0);
    checkOutput("rst_alu_a", int'(alu_a), 0);
    checkOutput("rst_alu_b", int'(alu_b), 0);
    checkOutput("rst_alu_sel", int'(alu_sel), 0);
    checkOutput("rst_op_count", int'(op_count), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_mismatch", int'(mismatch), 0);

    // Single add, latency from acceptance edge T
    applyStimulus(2'd0, 4'd9, 4'd8);
    checkOutput("lat_t0_rsp_valid", int'(rsp_valid), 0);
    @(posedge clk); #1;
    checkOutput("lat_t1_alu_a", int'(alu_a), 9);
    checkOutput("lat_t1_alu_b", int'(alu_b), 8);
    checkOutput("lat_t1_alu_sel", int'(alu_sel), 0);
    checkOutput("lat_t1_rsp_valid", int'(rsp_valid), 0);
    @(posedge clk); #1;
    checkOutput("lat_t2_rsp_valid", int'(rsp_valid), 1);
    checkOutput("lat_t2_rsp_y", int'(rsp_y), 1);
    checkOutput("lat_t2_rsp_op", int'(rsp_op), 0);
    waitIdle();
    checkOutput("single_op_count", int'(op_count), 1);

    // All ops on a=5, b=12
    for (int op = 0; op < 4; op++) applyStimulus(2'(op), 4'd5, 4'd12);
    waitIdle();
    checkOutput("allops_op_count", int'(op_count), 5);

    // Backpressure: one in flight plus four queued fills the block
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus(2'(i % 4), 4'(3 * i + 1), 4'(i + 2));
    repeat (3) @(posedge clk);
    #1;
    checkOutput("bp_cmd_ready", int'(cmd_ready), 0);
    checkOutput("bp_rsp_valid", int'(rsp_valid), 1);
    checkOutput("bp_rsp_y_held", int'(rsp_y), int'(alu_ref(2'd0, 4'd1, 4'd2)));
    checkOutput("bp_busy", int'(busy), 1);
    waitIdle();
    checkOutput("bp_op_count", int'(op_count), 10);

    // Randomized commands with random response backpressure
    rand_ready = 1;
    for (int i = 0; i < 200; i++) begin
      applyStimulus(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) stepCycle();
    end
    waitIdle();

    // Complete the remaining responses up to 256 so op_count wraps to 0
    remaining = (256 - exp_count) % 256;
    rand_ready = 1;
    for (int i = 0; i < remaining; i++)
      applyStimulus(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    waitIdle();
    checkOutput("wrap_op_count", int'(op_count), 0);

    // Reset while waiting on the ALU with a second command queued
    rsp_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_op = 2'd1; cmd_a = 4'd3; cmd_b = 4'd7;
    @(negedge clk);
    checkOutput("rstw_accept_a", int'(cmd_ready), 1);
    @(posedge clk); #1;
    cmd_op = 2'd3; cmd_a = 4'd6; cmd_b = 4'd9;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    checkOutput("rstw_busy_before", int'(busy), 1);
    checkOutput("rstw_no_rsp_yet", int'(rsp_valid), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("rstw_rsp_valid", int'(rsp_valid), 0);
    checkOutput("rstw_busy", int'(busy), 0);
    checkOutput("rstw_cmd_ready", int'(cmd_ready), 1);
    checkOutput("rstw_op_count", int'(op_count), 0);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("rstw_still_quiet", int'(rsp_valid), 0);
    checkOutput("rstw_still_idle", int'(busy), 0);

`ifdef ALU_CHECK_EN
    // Faulty ALU output raises the sticky mismatch flag
    zero_alu = 1;
    applyStimulus(2'd0, 4'd1, 4'd1);
    waitIdle();
    zero_alu = 0;
    checkOutput("chk_mismatch_set", int'(mismatch), 1);
    applyStimulus(2'd2, 4'd7, 4'd3);
    waitIdle();
    checkOutput("chk_mismatch_sticky", int'(mismatch), 1);
    doReset();
    checkOutput("chk_mismatch_cleared", int'(mismatch), 0);
`else
    applyStimulus(2'd0, 4'd1, 4'd1);
    waitIdle();
    checkOutput("nochk_mismatch", int'(mismatch), 0);
`endif

    @(posedge clk); #1;
    checkOutput("model_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
